// File: rtl/cache_controller.sv
// cache_controller: initiator side of a 2-way data cache, placed between the
// pipeline memory stage and the SRAM controller.
//   - Read hits are answered in the same cycle from the cache (cache_R_EN).
//   - Read misses fetch a 64-bit line from SRAM, fill the cache (cache_W_EN)
//     and forward the requested word.
//   - Stores are write-through, no-allocate: invalidate, then write SRAM.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   address, wdata                CPU byte address / store data
//   MEM_R_EN, MEM_W_EN            CPU load / store request (store wins)
//   rdata, ready                  load data / request-complete (stall when 0)
//   cache_addr, cache_R_EN, cache_W_EN, cache_invalidate, cache_data_in
//                                 cache-side address, strobes and fill line
//   cache_hit, cache_data_out     cache lookup result for cache_addr
//   sram_address, sram_wdata, sram_read_en, sram_write_en
//                                 SRAM-side request
//   sram_rdata, sram_ready        SRAM line and one-cycle completion pulse
// Optional feature (macro CACHE_STATS_EN): adds hit_count / miss_count
// saturating 16-bit statistics outputs.
module cache_controller #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [18:0]       cache_addr,
  output logic              cache_R_EN,
  output logic              cache_W_EN,
  output logic              cache_invalidate,
  output logic [63:0]       cache_data_in,
  input  logic              cache_hit,
  input  logic [31:0]       cache_data_out,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_wdata,
  output logic              sram_read_en,
  output logic              sram_write_en,
  input  logic [63:0]       sram_rdata,
  input  logic              sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] w_off;
  logic              w_rd_req;
  logic              w_wr_req;
  logic [31:0]       w_word;

  // Offset into cache/SRAM space, wraps modulo 2^ADDR_W
  assign w_off        = address - ADDR_W'(BASE_ADDR);
  assign cache_addr   = w_off[18:0];
  assign sram_address = w_off;
  assign sram_wdata   = wdata;
  assign cache_data_in = sram_rdata;

  // A simultaneous load+store is handled as a store
  assign w_wr_req = MEM_W_EN;
  assign w_rd_req = MEM_R_EN & ~MEM_W_EN;

  // Word select matches the cache: off[2]=1 -> low half, off[2]=0 -> high half
  assign w_word = w_off[2] ? sram_rdata[31:0] : sram_rdata[63:32];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and same-cycle handshake outputs
  always_comb begin
    w_next           = r_state;
    ready            = 1'b1;
    rdata            = 32'd0;
    cache_R_EN       = 1'b0;
    cache_W_EN       = 1'b0;
    cache_invalidate = 1'b0;
    sram_read_en     = 1'b0;
    sram_write_en    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          cache_invalidate = 1'b1;
          ready            = 1'b0;
          w_next           = WR_WAIT;
        end else if (w_rd_req) begin
          if (cache_hit) begin
            cache_R_EN = 1'b1;
            rdata      = cache_data_out;
          end else begin
            ready  = 1'b0;
            w_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        sram_read_en = 1'b1;
        if (sram_ready) begin
          cache_W_EN = 1'b1;
          rdata      = w_word;
          w_next     = IDLE;
        end else begin
          ready = 1'b0;
        end
      end
      WR_WAIT: begin
        sram_write_en = 1'b1;
        if (sram_ready) w_next = IDLE;
        else            ready  = 1'b0;
      end
      default: w_next = IDLE;
    endcase

    // Reset drops any pending SRAM request and quiets every strobe
    if (rst) begin
      w_next           = IDLE;
      ready            = ~(MEM_R_EN | MEM_W_EN);
      rdata            = 32'd0;
      cache_R_EN       = 1'b0;
      cache_W_EN       = 1'b0;
      cache_invalidate = 1'b0;
      sram_read_en     = 1'b0;
      sram_write_en    = 1'b0;
    end
  end

`ifdef CACHE_STATS_EN
  logic w_miss_evt;

  assign w_miss_evt = (r_state == IDLE) && (w_next == RD_WAIT) && !rst;

  // Saturating hit/miss statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else begin
      if (cache_R_EN && (hit_count != 16'hFFFF))
        hit_count <= hit_count + 16'd1;
      if (w_miss_evt && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus tasks push the expected
// outcome of each request; a negedge monitor tracks each request from issue
// to ready=1 and compares what it observed against the queued entry.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [18:0] cache_addr;
  logic        cache_R_EN, cache_W_EN, cache_invalidate;
  logic [63:0] cache_data_in;
  logic        cache_hit;
  logic [31:0] cache_data_out;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_read_en, sram_write_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_controller #(.ADDR_W(32), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .cache_addr(cache_addr), .cache_R_EN(cache_R_EN), .cache_W_EN(cache_W_EN),
    .cache_invalidate(cache_invalidate), .cache_data_in(cache_data_in),
    .cache_hit(cache_hit), .cache_data_out(cache_data_out),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_rd;
    logic        is_fill;
    logic [31:0] rdata;
    int          stall;
    int          ren;
    int          wen;
    int          inval;
    int          srd;
    int          swr;
    logic [31:0] saddr;
    logic [18:0] caddr;
    logic [31:0] swdata;
    logic [63:0] line;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Per-request observations
  int          m_stall, m_ren, m_wen, m_inval, m_srd, m_swr;
  logic [63:0] m_line;

  task automatic m_clear();
    m_stall = 0; m_ren = 0; m_wen = 0; m_inval = 0; m_srd = 0; m_swr = 0;
    m_line = 64'd0;
  endtask

  initial m_clear();

  // Monitor: accumulates over a request, compares on its ready=1 cycle
  always @(negedge clk) begin
    if (rst) begin
      m_clear();
    end else begin
      chk("strobe_excl",
          64'($countones({cache_R_EN, cache_W_EN, cache_invalidate}) > 1), 64'd0);
      if (MEM_R_EN || MEM_W_EN) begin
        if (!ready) m_stall++;
        if (cache_R_EN) m_ren++;
        if (cache_W_EN) begin m_wen++; m_line = cache_data_in; end
        if (cache_invalidate) m_inval++;
        if (sram_read_en) m_srd++;
        if (sram_write_en) m_swr++;
        if (ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("stall", 64'(m_stall), 64'(e.stall));
            chk("cache_R_EN", 64'(m_ren), 64'(e.ren));
            chk("cache_W_EN", 64'(m_wen), 64'(e.wen));
            chk("invalidate", 64'(m_inval), 64'(e.inval));
            chk("sram_read_en", 64'(m_srd), 64'(e.srd));
            chk("sram_write_en", 64'(m_swr), 64'(e.swr));
            chk("sram_address", 64'(sram_address), 64'(e.saddr));
            chk("cache_addr", 64'(cache_addr), 64'(e.caddr));
            if (e.is_rd) chk("rdata", 64'(rdata), 64'(e.rdata));
            else         chk("sram_wdata", 64'(sram_wdata), 64'(e.swdata));
            if (e.is_fill) chk("fill_line", m_line, e.line);
          end
          m_clear();
        end
      end
    end
  end

  // Load: hit answered from cdata, miss answered by SRAM after lat cycles
  task automatic do_read(input logic [31:0] addr, input logic [18:0] caddr,
                         input logic [31:0] saddr, input logic hit,
                         input logic [31:0] cdata, input logic [63:0] line,
                         input int lat, input logic [31:0] exp_rd);
    exp_t e;
    e = '{default: 0};
    e.is_rd = 1'b1; e.is_fill = !hit; e.rdata = exp_rd;
    e.saddr = saddr; e.caddr = caddr; e.line = line;
    if (hit) e.ren = 1;
    else begin e.stall = lat; e.srd = lat; e.wen = 1; end
    sb.push_back(e);
    address = addr; MEM_R_EN = 1'b1; cache_hit = hit; cache_data_out = cdata;
    @(posedge clk); #1;
    if (!hit) begin
      for (int i = 1; i <= lat; i++) begin
        if (i == lat) begin sram_ready = 1'b1; sram_rdata = line; end
        @(posedge clk); #1;
      end
      sram_ready = 1'b0;
    end
    MEM_R_EN = 1'b0; cache_hit = 1'b0;
  endtask

  // Store (optionally with MEM_R_EN also high and a tempting cache hit)
  task automatic do_write(input logic [31:0] addr, input logic [18:0] caddr,
                          input logic [31:0] saddr, input logic [31:0] data,
                          input int lat, input logic both);
    exp_t e;
    e = '{default: 0};
    e.is_rd = 1'b0; e.stall = lat; e.inval = 1; e.swr = lat;
    e.saddr = saddr; e.caddr = caddr; e.swdata = data;
    sb.push_back(e);
    address = addr; wdata = data; MEM_W_EN = 1'b1; MEM_R_EN = both;
    cache_hit = both; cache_data_out = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) sram_ready = 1'b1;
      @(posedge clk); #1;
    end
    sram_ready = 1'b0; MEM_W_EN = 1'b0; MEM_R_EN = 1'b0; cache_hit = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, 64'({cache_R_EN, cache_W_EN, cache_invalidate,
                   sram_read_en, sram_write_en}), 64'd0);
    chk({name, "_ready"}, 64'(ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; address = 32'd0; wdata = 32'd0; MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0; cache_hit = 1'b0; cache_data_out = 32'd0;
    sram_rdata = 64'd0; sram_ready = 1'b0;

    // Reset: two cycles, quiet outputs during and after
    @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");
    @(posedge clk); #1;

    // Cold miss at 0x408 (off 0x8, bit2=0 -> high word), SRAM latency 5
    do_read(32'h0000_0408, 19'h8, 32'h8, 1'b0, 32'd0,
            64'hAAAA_0001_BBBB_0002, 5, 32'hAAAA_0001);
    // Immediate hit at 0x40C
    do_read(32'h0000_040C, 19'hC, 32'hC, 1'b1, 32'hBBBB_0002,
            64'd0, 0, 32'hBBBB_0002);
    // Store, then the same address misses again
    do_write(32'h0000_0408, 19'h8, 32'h8, 32'hDEAD_BEEF, 3, 1'b0);
    do_read(32'h0000_0408, 19'h8, 32'h8, 1'b0, 32'd0,
            64'h1111_2222_3333_4444, 2, 32'h1111_2222);
    // Miss with minimum SRAM latency, low word (off bit2=1)
    do_read(32'h0000_040C, 19'hC, 32'hC, 1'b0, 32'd0,
            64'h5555_6666_7777_8888, 1, 32'h7777_8888);
    // Address below BASE_ADDR wraps: off = 0xFFFF_FC04
    do_read(32'h0000_0004, 19'h7FC04, 32'hFFFF_FC04, 1'b1, 32'h1234_5678,
            64'd0, 0, 32'h1234_5678);
    // Load and store together -> store path, no cache_R_EN
    do_write(32'h0000_0410, 19'h10, 32'h10, 32'hCAFE_F00D, 2, 1'b1);

    // Stray sram_ready in IDLE is ignored
    sram_ready = 1'b1;
    @(negedge clk);
    chk_quiet("idle_sram_ready");
    @(posedge clk); #1;
    sram_ready = 1'b0;
    do_read(32'h0000_0500, 19'h100, 32'h100, 1'b1, 32'h0000_00A5,
            64'd0, 0, 32'h0000_00A5);
`ifdef CACHE_STATS_EN
    @(negedge clk);
    chk("hit_count", 64'(hit_count), 64'd3);
    chk("miss_count", 64'(miss_count), 64'd3);
    @(posedge clk); #1;
`endif

    // Reset while waiting on SRAM aborts the read
    address = 32'h0000_0408; MEM_R_EN = 1'b1; cache_hit = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_wait_sram_read_en", 64'(sram_read_en), 64'd1);
    chk("rd_wait_ready", 64'(ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; MEM_R_EN = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("abort");
`ifdef CACHE_STATS_EN
    chk("abort_hit_count", 64'(hit_count), 64'd0);
    chk("abort_miss_count", 64'(miss_count), 64'd0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("abort_next");
    @(posedge clk); #1;

    chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
